// File: rtl/saturating_narrow_pkg.sv
// saturating_narrow_pkg: saturation limits and range check shared by narrowing blocks
package saturating_narrow_pkg;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
  // a value fits in ow signed bits when every bit from ow-1 upward matches the ow-1 sign bit
  function automatic logic out_of_range(input logic [63:0] x, input int iw, input int ow);
    logic r;
    r = 1'b0;
    for (int i = ow; i < iw; i++) r = r | (x[i] ^ x[ow-1]);
    return r;
  endfunction
endpackage

// File: rtl/saturating_narrow_skid_buffer.sv
// saturating_narrow_skid_buffer: one-entry skid buffer with registered ready
module saturating_narrow_skid_buffer #(
  parameter int p_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [p_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [p_WIDTH-1:0] skid_q;
  logic skid_full, out_free, in_xfer;
  assign in_ready = ~skid_full;
  assign in_xfer = in_valid & ~skid_full;
  assign out_free = ~out_valid | out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      skid_full <= 1'b0;
      skid_q <= '0;
    end else if (out_free) begin
      out_valid <= skid_full | in_xfer;
      if (skid_full | in_xfer) out_data <= skid_full ? skid_q : in_data;
      skid_full <= 1'b0;
    end else if (in_xfer) begin
      skid_q <= in_data;
      skid_full <= 1'b1;
    end
endmodule

// File: rtl/saturating_narrow.sv
// saturating_narrow: signed narrowing with saturate/wrap, skid-buffered handshake and overflow stats
module saturating_narrow
  import saturating_narrow_pkg::*;
#(
  parameter int p_INPUT_WIDTH  = 8,
  parameter int p_OUTPUT_WIDTH = 4,
  parameter int p_SATURATE     = 1,
  parameter int p_COUNT_WIDTH  = 8
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [p_INPUT_WIDTH-1:0]  i_INPUT,
  input  logic                      i_VALID,
  output logic                      o_READY,
  output logic [p_OUTPUT_WIDTH-1:0] o_OUTPUT,
  output logic                      o_VALID,
  input  logic                      i_READY,
  output logic                      o_OVF,
  output logic                      o_OVF_STICKY,
  output logic [p_COUNT_WIDTH-1:0]  o_SAT_COUNT,
  input  logic                      i_CLR
);
  localparam logic [p_OUTPUT_WIDTH-1:0] lim_max = p_OUTPUT_WIDTH'(sat_max(p_OUTPUT_WIDTH));
  localparam logic [p_OUTPUT_WIDTH-1:0] lim_min = p_OUTPUT_WIDTH'(sat_min(p_OUTPUT_WIDTH));
  logic oor, accept;
  logic [p_OUTPUT_WIDTH-1:0] narrow;
  assign oor = out_of_range(64'(i_INPUT), p_INPUT_WIDTH, p_OUTPUT_WIDTH);
  assign narrow = (p_SATURATE != 0 && oor) ? (i_INPUT[p_INPUT_WIDTH-1] ? lim_min : lim_max)
                                           : i_INPUT[p_OUTPUT_WIDTH-1:0];
  assign accept = i_VALID & o_READY;
  saturating_narrow_skid_buffer #(.p_WIDTH(p_OUTPUT_WIDTH + 1)) u_skid (
    .clk(i_CLK),
    .rst(i_RST),
    .in_data({oor, narrow}),
    .in_valid(i_VALID),
    .in_ready(o_READY),
    .out_data({o_OVF, o_OUTPUT}),
    .out_valid(o_VALID),
    .out_ready(i_READY)
  );
  // stats track acceptance; a coincident overflow beats i_CLR
  always_ff @(posedge i_CLK)
    if (i_RST) begin
      o_OVF_STICKY <= 1'b0;
      o_SAT_COUNT <= '0;
    end else begin
      o_OVF_STICKY <= (accept & oor) | (o_OVF_STICKY & ~i_CLR);
      if (accept & oor) o_SAT_COUNT <= i_CLR ? p_COUNT_WIDTH'(1) : (&o_SAT_COUNT) ? o_SAT_COUNT : o_SAT_COUNT + p_COUNT_WIDTH'(1);
      else if (i_CLR) o_SAT_COUNT <= '0;
    end
`ifndef SYNTHESIS
  always_comb assert (oor || {{(p_INPUT_WIDTH-p_OUTPUT_WIDTH){narrow[p_OUTPUT_WIDTH-1]}}, narrow} == i_INPUT);
  assert property (@(posedge i_CLK) disable iff (i_RST) o_VALID && !i_READY |=> o_VALID && $stable({o_OVF, o_OUTPUT}));
  assert property (@(posedge i_CLK) disable iff (i_RST) !i_CLR |=> o_SAT_COUNT >= $past(o_SAT_COUNT));
`endif
endmodule

// File: tb/tb_saturating_narrow.sv
// tb_saturating_narrow: three configurations (saturate, wrap, 2-bit counter) against an arithmetic model
module tb_saturating_narrow;
  logic clk = 1'b0;
  logic rst, valid, ready, clr;
  logic [7:0] din;
  logic [2:0][3:0] out;
  logic [2:0] vld, rdy, ovf, stk;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  int cm[3] = '{0, 0, 0};
  bit sm[3] = '{1'b0, 1'b0, 1'b0};
  bit sat_of[3] = '{1'b1, 1'b0, 1'b1};
  int cmax[3] = '{255, 255, 3};
  logic [7:0] inr[4] = '{8'hF9, 8'h05, 8'hF8, 8'h07};
  logic [7:0] ovr[4] = '{8'h7F, 8'h08, 8'h80, 8'hF7};
  int sent;
  bit saw_drop, acc0, pend;

  always #5 clk = ~clk;

  saturating_narrow d0 (.i_CLK(clk), .i_RST(rst), .i_INPUT(din), .i_VALID(valid), .o_READY(rdy[0]),
    .o_OUTPUT(out[0]), .o_VALID(vld[0]), .i_READY(ready), .o_OVF(ovf[0]), .o_OVF_STICKY(stk[0]),
    .o_SAT_COUNT(cnt0), .i_CLR(clr));
  saturating_narrow #(.p_SATURATE(0)) d1 (.i_CLK(clk), .i_RST(rst), .i_INPUT(din), .i_VALID(valid),
    .o_READY(rdy[1]), .o_OUTPUT(out[1]), .o_VALID(vld[1]), .i_READY(ready), .o_OVF(ovf[1]),
    .o_OVF_STICKY(stk[1]), .o_SAT_COUNT(cnt1), .i_CLR(clr));
  saturating_narrow #(.p_COUNT_WIDTH(2)) d2 (.i_CLK(clk), .i_RST(rst), .i_INPUT(din), .i_VALID(valid),
    .o_READY(rdy[2]), .o_OUTPUT(out[2]), .o_VALID(vld[2]), .i_READY(ready), .o_OVF(ovf[2]),
    .o_OVF_STICKY(stk[2]), .o_SAT_COUNT(cnt2), .i_CLR(clr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {overflow, narrowed word} from signed-integer arithmetic
  function automatic logic [4:0] model(input logic [7:0] w, input bit s);
    int v;
    bit o;
    v = $signed(w);
    o = v < -8 || v > 7;
    return {o, 4'((o && s) ? (v < 0 ? -8 : 7) : v)};
  endfunction

  function automatic int cnt_of(input int k);
    return k == 0 ? int'(cnt0) : k == 1 ? int'(cnt1) : int'(cnt2);
  endfunction

  // one clock: check pre-edge outputs against the in-flight queue, advance the model, check stats after
  task automatic tick();
    logic [4:0] m;
    bit acc, pop;
    acc = valid && rdy[0];
    pop = vld[0] && ready;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("valid%0d", k), 32'(vld[k]), 32'(q.size() > 0));
      check($sformatf("ready%0d", k), 32'(rdy[k]), 32'(q.size() < 2));
      if (vld[k] && q.size() > 0) begin
        m = model(q[0], sat_of[k]);
        check($sformatf("data%0d", k), 32'({ovf[k], out[k]}), 32'(m));
      end
      m = model(din, sat_of[k]);
      if (rst) begin
        cm[k] = 0;
        sm[k] = 0;
      end else if (acc && m[4]) begin
        cm[k] = clr ? 1 : (cm[k] < cmax[k] ? cm[k] + 1 : cm[k]);
        sm[k] = 1;
      end else if (clr) begin
        cm[k] = 0;
        sm[k] = 0;
      end
    end
    if (rst) q.delete();
    else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(din);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("count%0d", k), 32'(cnt_of(k)), 32'(cm[k]));
      check($sformatf("sticky%0d", k), 32'(stk[k]), 32'(sm[k]));
    end
  endtask

  task automatic send(input logic [7:0] w);
    valid = 1'b1;
    din = w;
    tick();
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b1; clr = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out", 32'(out[0]), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_ready", 32'(rdy), 32'h7);
    idle(1);
    for (int i = 0; i < 4; i++) send(inr[i]);
    idle(2);
    check("inrange_count", 32'(cnt0), 32'd0);
    for (int i = 0; i < 4; i++) send(ovr[i]);
    idle(2);
    check("sat_count", 32'(cnt0), 32'd4);
    check("sat_sticky", 32'(stk[0]), 32'd1);
    clr = 1'b1; idle(1); clr = 1'b0;
    send(8'h7F);
    send(8'h23);
    idle(2);
    check("wrap_count", 32'(cnt1), 32'd2);
    sent = 0; saw_drop = 1'b0;
    for (int c = 0; c < 40 && sent < 6; c++) begin
      ready = !(c >= 3 && c < 6);
      valid = 1'b1;
      din = 8'(sent + 1);
      acc0 = rdy[0];
      if (!rdy[0]) saw_drop = 1'b1;
      tick();
      if (acc0) sent++;
    end
    ready = 1'b1;
    idle(3);
    check("bp_sent", 32'(sent), 32'd6);
    check("bp_ready_drop", 32'(saw_drop), 32'd1);
    clr = 1'b1; idle(1); clr = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h80);
    idle(2);
    check("limit_count", 32'(cnt2), 32'd3);
    clr = 1'b1; send(8'h40); clr = 1'b0;
    check("clr_set_count", 32'(cnt2), 32'd1);
    check("clr_set_sticky", 32'(stk[2]), 32'd1);
    idle(2);
    pend = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!pend) begin
        valid = ($urandom % 4) != 0;
        din = 8'($urandom);
      end
      ready = ($urandom % 3) != 0;
      clr = ($urandom % 16) == 0;
      pend = valid && !rdy[0];
      tick();
    end
    clr = 1'b0; ready = 1'b1;
    idle(3);
    ready = 1'b0; valid = 1'b1; din = 8'h7B;
    for (int c = 0; c < 10 && rdy[0]; c++) tick();
    check("pre_rst_valid", 32'(vld[0]), 32'd1);
    check("pre_rst_ready", 32'(rdy[0]), 32'd0);
    valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_valid", 32'(vld), 32'h0);
    check("post_rst_ready", 32'(rdy), 32'h7);
    check("post_rst_out", 32'(out[0]), 32'h0);
    check("post_rst_count", 32'(cnt0), 32'h0);
    ready = 1'b1;
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
